// File: rtl/cfg_access_arbiter.sv
// Two-port round-robin arbiter onto the single P-tile config-access path.
// One transaction in flight at a time, bounded by a programmable timeout.
module cfg_access_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_WIDTH-1:0]  timeout_cycles_i,
  input  logic                  m0_valid_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_ready_o,
  output logic                  m0_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] m0_rsp_data_o,
  output logic                  m0_rsp_err_o,
  input  logic                  m1_valid_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_ready_o,
  output logic                  m1_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] m1_rsp_data_o,
  output logic                  m1_rsp_err_o,
  output logic                  cfg_valid_o,
  output logic                  cfg_write_o,
  output logic [ADDR_WIDTH-1:0] cfg_addr_o,
  output logic [DATA_WIDTH-1:0] cfg_wdata_o,
  input  logic                  cfg_ready_i,
  input  logic                  cfg_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] cfg_rsp_data_i,
  input  logic [RESP_WIDTH-1:0] cfg_rsp_status_i,
  output logic                  timeout_o,
  output logic                  stale_rsp_o,
  output logic                  busy_o
);

  // Handshake: a requester holds valid/write/addr/wdata stable until it sees
  // its one-cycle ready pulse; downstream cfg_valid_o holds until cfg_ready_i.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  last_grant_q;
  logic                  owner_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cfg_valid_q;
  logic [REG_WIDTH-1:0]  cnt_q;
  logic                  tmo_en_q;
  logic                  m0_ready_q, m1_ready_q;
  logic                  m0_rsp_valid_q, m1_rsp_valid_q;
  logic [DATA_WIDTH-1:0] m0_rsp_data_q, m1_rsp_data_q;
  logic                  m0_rsp_err_q, m1_rsp_err_q;
  logic                  timeout_q;
  logic                  stale_q;

  logic                  grant_req_d;
  logic                  grant_port_d;
  logic                  in_flight_d;
  logic                  rsp_capture_d;
  logic                  expire_d;
  logic                  stale_d;
  logic                  done_d;
  logic                  done_err_d;
  logic [DATA_WIDTH-1:0] done_data_d;

  assign grant_req_d   = m0_valid_i | m1_valid_i;
  assign grant_port_d  = (m0_valid_i & m1_valid_i) ? ~last_grant_q : m1_valid_i;
  assign in_flight_d   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign rsp_capture_d = cfg_rsp_valid_i &&
                         (((state_q == ST_ISSUE) && cfg_ready_i) || (state_q == ST_WAIT));
  // A completion landing in the expiry cycle takes priority over the timeout.
  assign expire_d      = in_flight_d && tmo_en_q && (cnt_q == REG_WIDTH'(1)) && !rsp_capture_d;
  assign stale_d       = cfg_rsp_valid_i && !rsp_capture_d && (state_q != ST_WAIT);
  assign done_d        = rsp_capture_d || expire_d;
  assign done_err_d    = expire_d || (cfg_rsp_status_i != '0);
  assign done_data_d   = done_err_d ? '1 : (write_q ? '0 : cfg_rsp_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      write_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cfg_valid_q    <= 1'b0;
      cnt_q          <= '0;
      tmo_en_q       <= 1'b0;
      m0_ready_q     <= 1'b0;
      m1_ready_q     <= 1'b0;
      m0_rsp_valid_q <= 1'b0;
      m1_rsp_valid_q <= 1'b0;
      m0_rsp_data_q  <= '0;
      m1_rsp_data_q  <= '0;
      m0_rsp_err_q   <= 1'b0;
      m1_rsp_err_q   <= 1'b0;
      timeout_q      <= 1'b0;
      stale_q        <= 1'b0;
    end else begin
      m0_ready_q     <= 1'b0;
      m1_ready_q     <= 1'b0;
      m0_rsp_valid_q <= 1'b0;
      m1_rsp_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      stale_q        <= stale_d;
      if (in_flight_d && tmo_en_q) cnt_q <= cnt_q - REG_WIDTH'(1);
      case (state_q)
        ST_IDLE: begin
          if (grant_req_d) begin
            owner_q      <= grant_port_d;
            last_grant_q <= grant_port_d;
            m0_ready_q   <= ~grant_port_d;
            m1_ready_q   <= grant_port_d;
            write_q      <= grant_port_d ? m1_write_i : m0_write_i;
            addr_q       <= grant_port_d ? m1_addr_i  : m0_addr_i;
            wdata_q      <= grant_port_d ? m1_wdata_i : m0_wdata_i;
            cnt_q        <= timeout_cycles_i;
            tmo_en_q     <= |timeout_cycles_i;
            cfg_valid_q  <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (done_d) begin
            cfg_valid_q <= 1'b0;
            timeout_q   <= expire_d;
            state_q     <= ST_RESP;
            if (owner_q) begin
              m1_rsp_valid_q <= 1'b1;
              m1_rsp_data_q  <= done_data_d;
              m1_rsp_err_q   <= done_err_d;
            end else begin
              m0_rsp_valid_q <= 1'b1;
              m0_rsp_data_q  <= done_data_d;
              m0_rsp_err_q   <= done_err_d;
            end
          end else if ((state_q == ST_ISSUE) && cfg_ready_i) begin
            cfg_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m0_ready_o     = m0_ready_q;
  assign m1_ready_o     = m1_ready_q;
  assign m0_rsp_valid_o = m0_rsp_valid_q;
  assign m1_rsp_valid_o = m1_rsp_valid_q;
  assign m0_rsp_data_o  = m0_rsp_data_q;
  assign m1_rsp_data_o  = m1_rsp_data_q;
  assign m0_rsp_err_o   = m0_rsp_err_q;
  assign m1_rsp_err_o   = m1_rsp_err_q;
  assign cfg_valid_o    = cfg_valid_q;
  assign cfg_write_o    = write_q;
  assign cfg_addr_o     = addr_q;
  assign cfg_wdata_o    = wdata_q;
  assign timeout_o      = timeout_q;
  assign stale_rsp_o    = stale_q;
  assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cfg_access_arbiter.sv
// Directed bench for cfg_access_arbiter: arbitration, completions, timeouts,
// stale completions and asynchronous reset.
module tb_cfg_access_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] timeout_cycles;
  logic        m0_valid, m0_write, m1_valid, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready_o, m0_rsp_valid_o, m0_rsp_err_o;
  logic        m1_ready_o, m1_rsp_valid_o, m1_rsp_err_o;
  logic [31:0] m0_rsp_data_o, m1_rsp_data_o;
  logic        cfg_valid_o, cfg_write_o;
  logic [31:0] cfg_addr_o, cfg_wdata_o;
  logic        cfg_ready, cfg_rsp_valid;
  logic [31:0] cfg_rsp_data;
  logic [1:0]  cfg_rsp_status;
  logic        timeout_o, stale_rsp_o, busy_o;

  int total = 0;
  int bad   = 0;

  cfg_access_arbiter dut (
    .clk_i(clk), .rst_i(rst), .timeout_cycles_i(timeout_cycles),
    .m0_valid_i(m0_valid), .m0_write_i(m0_write), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ready_o(m0_ready_o), .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_data_o(m0_rsp_data_o),
    .m0_rsp_err_o(m0_rsp_err_o),
    .m1_valid_i(m1_valid), .m1_write_i(m1_write), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ready_o(m1_ready_o), .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_data_o(m1_rsp_data_o),
    .m1_rsp_err_o(m1_rsp_err_o),
    .cfg_valid_o(cfg_valid_o), .cfg_write_o(cfg_write_o), .cfg_addr_o(cfg_addr_o),
    .cfg_wdata_o(cfg_wdata_o), .cfg_ready_i(cfg_ready), .cfg_rsp_valid_i(cfg_rsp_valid),
    .cfg_rsp_data_i(cfg_rsp_data), .cfg_rsp_status_i(cfg_rsp_status),
    .timeout_o(timeout_o), .stale_rsp_o(stale_rsp_o), .busy_o(busy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rsp_valid_of(input int port);
    return (port == 1) ? m1_rsp_valid_o : m0_rsp_valid_o;
  endfunction

  function automatic logic [31:0] rsp_data_of(input int port);
    return (port == 1) ? m1_rsp_data_o : m0_rsp_data_o;
  endfunction

  function automatic logic rsp_err_of(input int port);
    return (port == 1) ? m1_rsp_err_o : m0_rsp_err_o;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Driver: present one request on a port and check the grant cycle.
  task automatic issue_req(input int port, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    if (port == 0) begin
      m0_valid = 1'b1; m0_write = wr; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_valid = 1'b1; m1_write = wr; m1_addr = addr; m1_wdata = wdata;
    end
    step();
    chk("grant_ready_own",   (port == 1) ? m1_ready_o : m0_ready_o, 1'b1);
    chk("grant_ready_other", (port == 1) ? m0_ready_o : m1_ready_o, 1'b0);
    chk("issue_valid", cfg_valid_o, 1'b1);
    chk("issue_addr",  cfg_addr_o, addr);
    chk("issue_write", cfg_write_o, wr);
    chk("issue_wdata", cfg_wdata_o, wdata);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  // Downstream accepts at once; completion comes with the accept (delay 0)
  // or rsp_delay cycles later.
  task automatic complete(input int port, input int rsp_delay, input logic [31:0] rdata,
                          input logic [1:0] status, input logic [31:0] exp_data,
                          input logic exp_err);
    cfg_ready = 1'b1;
    if (rsp_delay == 0) begin
      cfg_rsp_valid = 1'b1; cfg_rsp_data = rdata; cfg_rsp_status = status;
    end
    step();
    cfg_ready = 1'b0;
    if (rsp_delay > 0) begin
      chk("accept_drop", cfg_valid_o, 1'b0);
      repeat (rsp_delay - 1) step();
      chk("wait_busy", busy_o, 1'b1);
      chk("wait_no_rsp", rsp_valid_of(port), 1'b0);
      cfg_rsp_valid = 1'b1; cfg_rsp_data = rdata; cfg_rsp_status = status;
      step();
    end
    cfg_rsp_valid = 1'b0;
    chk("rsp_valid_own",   rsp_valid_of(port), 1'b1);
    chk("rsp_valid_other", rsp_valid_of(1 - port), 1'b0);
    chk("rsp_data", rsp_data_of(port), exp_data);
    chk("rsp_err",  rsp_err_of(port), exp_err);
    chk("rsp_no_timeout", timeout_o, 1'b0);
    step();
    chk("rsp_pulse_end", rsp_valid_of(port), 1'b0);
    chk("rsp_idle", busy_o, 1'b0);
  endtask

  // Transaction already granted with timeout 8; expect expiry 8 cycles after ISSUE entry.
  task automatic run_timeout(input int port, input logic accept_first);
    cfg_ready = accept_first;
    for (int k = 1; k <= 7; k++) begin
      step();
      cfg_ready = 1'b0;
      chk("tmo_early_pulse", timeout_o, 1'b0);
      chk("tmo_early_rsp", rsp_valid_of(port), 1'b0);
      chk("tmo_early_cfg_valid", cfg_valid_o, !accept_first);
    end
    step();
    chk("tmo_pulse", timeout_o, 1'b1);
    chk("tmo_rsp_valid", rsp_valid_of(port), 1'b1);
    chk("tmo_rsp_err", rsp_err_of(port), 1'b1);
    chk("tmo_rsp_data", rsp_data_of(port), 32'hFFFF_FFFF);
    chk("tmo_cfg_valid", cfg_valid_o, 1'b0);
    step();
    chk("tmo_pulse_end", timeout_o, 1'b0);
    chk("tmo_rsp_end", rsp_valid_of(port), 1'b0);
    chk("tmo_idle", busy_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    timeout_cycles = '0;
    m0_valid = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
    cfg_ready = 1'b0; cfg_rsp_valid = 1'b0; cfg_rsp_data = '0; cfg_rsp_status = '0;
    apply_reset();

    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cfg_valid", cfg_valid_o, 1'b0);
    chk("rst_ready0", m0_ready_o, 1'b0);
    chk("rst_rsp_valid1", m1_rsp_valid_o, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("rst_stale", stale_rsp_o, 1'b0);

    // Basic read with a 3-cycle completion latency
    issue_req(0, 1'b0, 32'h0000_0010, 32'h0);
    complete(0, 3, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);

    // Back-to-back ties alternate starting with port 0
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'h100 + i;
      m1_valid = 1'b1; m1_write = 1'b0; m1_addr = 32'h200 + i;
      step();
      chk("tie_ready0", m0_ready_o, g == 0);
      chk("tie_ready1", m1_ready_o, g == 1);
      chk("tie_addr", cfg_addr_o, (g == 1) ? 32'h200 + i : 32'h100 + i);
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      complete(g, 0, 32'h5000 + i, 2'b00, 32'h5000 + i, 1'b0);
    end

    // Read timeout in WAIT; a later timeout value must not matter; late completion is stale
    timeout_cycles = 32'd8;
    issue_req(1, 1'b0, 32'h0000_0044, 32'h0);
    timeout_cycles = 32'd3;
    run_timeout(1, 1'b1);
    cfg_rsp_valid = 1'b1; cfg_rsp_data = 32'h1111_2222; cfg_rsp_status = 2'b00;
    step();
    cfg_rsp_valid = 1'b0;
    chk("stale_pulse", stale_rsp_o, 1'b1);
    chk("stale_no_rsp0", m0_rsp_valid_o, 1'b0);
    chk("stale_no_rsp1", m1_rsp_valid_o, 1'b0);
    step();
    chk("stale_pulse_end", stale_rsp_o, 1'b0);

    // Completion in the expiry cycle wins over the timeout
    timeout_cycles = 32'd8;
    issue_req(0, 1'b0, 32'h0000_0048, 32'h0);
    complete(0, 7, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0);

    // Timeout disabled: a very slow completion still succeeds
    timeout_cycles = 32'd0;
    issue_req(1, 1'b0, 32'h0000_004C, 32'h0);
    complete(1, 1000, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 1'b0);

    // Writes: error status forces all-ones, success returns zero
    issue_req(0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    complete(0, 0, 32'h0BAD_0BAD, 2'b01, 32'hFFFF_FFFF, 1'b1);
    issue_req(1, 1'b1, 32'h0000_0024, 32'h5A5A_5A5A);
    complete(1, 0, 32'h0BAD_0BAD, 2'b00, 32'h0000_0000, 1'b0);

    // Downstream never accepts: abort from ISSUE
    timeout_cycles = 32'd8;
    issue_req(1, 1'b1, 32'h0000_0030, 32'h0000_0077);
    run_timeout(1, 1'b0);

    // Asynchronous reset in the middle of WAIT
    timeout_cycles = 32'd0;
    issue_req(0, 1'b0, 32'h0000_0040, 32'h0);
    cfg_ready = 1'b1;
    step();
    cfg_ready = 1'b0;
    step();
    step();
    chk("pre_rst_busy", busy_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_cfg_valid", cfg_valid_o, 1'b0);
    chk("arst_cfg_addr", cfg_addr_o, 32'h0);
    chk("arst_rsp_valid0", m0_rsp_valid_o, 1'b0);
    chk("arst_rsp_data0", m0_rsp_data_o, 32'h0);
    chk("arst_timeout", timeout_o, 1'b0);
    cfg_rsp_valid = 1'b1; cfg_rsp_data = 32'h7777_7777; cfg_rsp_status = 2'b00;
    step();
    cfg_rsp_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_rsp0", m0_rsp_valid_o, 1'b0);
    chk("post_rst_stale", stale_rsp_o, 1'b0);
    chk("post_rst_busy", busy_o, 1'b0);
    m0_valid = 1'b1; m0_write = 1'b0; m0_addr = 32'h0000_0050;
    m1_valid = 1'b1; m1_write = 1'b0; m1_addr = 32'h0000_0054;
    step();
    chk("post_rst_tie0", m0_ready_o, 1'b1);
    chk("post_rst_tie1", m1_ready_o, 1'b0);
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    complete(0, 0, 32'h0F0F_0F0F, 2'b00, 32'h0F0F_0F0F, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
